// File: rtl/gray_frame_sink.sv
// gray_frame_sink: end of the 8-bit grayscale pixel stream.
// It checks the geometry of each frame against H_ACT x V_ACT and turns every
// accepted pixel into a 16-bit word for the SDRAM write FIFO. The input
// stream cannot be stalled, so FIFO overflow and geometry faults are only
// flagged in sticky error bits.
// Optional build macro GRAY_SINK_RGB565_EN: replicates gray into RGB565.
// When the macro is undefined the word is zero-extended gray.
module gray_frame_sink #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_sop,
  input  logic        din_eop,
  input  logic        din_vld,
  input  logic [7:0]  din,
  input  logic        fifo_full,
  output logic        wr_en,
  output logic [15:0] wr_data,
  output logic        frame_done,
  output logic        err_geom,
  output logic        err_ovf
);

  localparam int XW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int YW = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACT - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        state_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  logic          at_last;
  logic          px_write;
  logic [15:0]   px_word;

  // The pixel being accepted sits at the final position of the frame.
  assign at_last = (x_q == X_LAST) && (y_q == Y_LAST);

  // Every sop pixel is written; inside a frame every valid pixel is written.
  assign px_write = din_vld && (din_sop || (state_q == S_RUN));

`ifdef GRAY_SINK_RGB565_EN
  assign px_word = {din[7:3], din[7:2], din[7:3]};
`else
  assign px_word = {8'h00, din};
`endif

  // Frame FSM with position counters, write port and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      err_geom   <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;

      if (din_vld) begin
        if (din_sop) begin
          // A sop always restarts the frame at pixel 1 of line 0. Outside a
          // frame it clears the flags; inside a frame it is a geometry fault.
          // sop together with eop closes a one-pixel frame, which can never
          // match a geometry of at least two pixels.
          x_q <= XW'(1);
          y_q <= '0;
          if (state_q == S_RUN) begin
            err_geom <= 1'b1;
          end else begin
            err_geom <= din_eop;
            err_ovf  <= 1'b0;
          end
          if (din_eop) begin
            err_geom <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            state_q  <= S_RUN;
          end
        end else if (state_q == S_RUN) begin
          if (din_eop) begin
            if (at_last) begin
              frame_done <= 1'b1;
            end else begin
              err_geom <= 1'b1;
            end
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
          end else if (at_last) begin
            // Frame is full but the source keeps going: drop until next sop.
            err_geom <= 1'b1;
            state_q  <= S_DROP;
            x_q      <= '0;
            y_q      <= '0;
          end else if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= y_q + 1'b1;
          end else begin
            x_q <= x_q + 1'b1;
          end
        end
      end

      // Write gating comes last so an overflow set beats a sop clear.
      if (px_write) begin
        if (fifo_full) begin
          err_ovf <= 1'b1;
        end else begin
          wr_en   <= 1'b1;
          wr_data <= px_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_frame_sink.sv
// Bench for gray_frame_sink with a 4x2 geometry: a table-driven good frame,
// hand-written corner sequences and randomized frames, all compared cycle by
// cycle against a pixel-count model of the frame rules.
module tb_gray_frame_sink;

  localparam int H = 4;
  localparam int V = 2;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_sop, din_eop, din_vld, fifo_full;
  logic [7:0]  din;
  logic        wr_en, frame_done, err_geom, err_ovf;
  logic [15:0] wr_data;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;

  // Model state: whether a frame is open and how many pixels it has taken.
  bit          m_in_frame;
  int          m_n;
  logic        m_we, m_done, m_geom, m_ovf;
  logic [15:0] m_data;

  gray_frame_sink #(.H_ACT(H), .V_ACT(V)) dut (
    .clk(clk), .rst(rst),
    .din_sop(din_sop), .din_eop(din_eop), .din_vld(din_vld), .din(din),
    .fifo_full(fifo_full),
    .wr_en(wr_en), .wr_data(wr_data), .frame_done(frame_done),
    .err_geom(err_geom), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word_of(input logic [7:0] d);
`ifdef GRAY_SINK_RGB565_EN
    return {d[7:3], d[7:2], d[7:3]};
`else
    return {8'h00, d};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: frame rules expressed as a pixel count within the open frame.
  task automatic model(input logic r, s, e, v, input logic [7:0] d, input logic f);
    bit write;
    write  = 1'b0;
    m_we   = 1'b0;
    m_done = 1'b0;
    if (r) begin
      m_in_frame = 0; m_n = 0;
      m_data = 16'h0; m_geom = 1'b0; m_ovf = 1'b0;
      return;
    end
    if (v) begin
      if (s) begin
        write = 1'b1;
        if (m_in_frame) m_geom = 1'b1;
        else begin m_geom = 1'b0; m_ovf = 1'b0; end
        if (e) m_geom = 1'b1;  // one-pixel frame never matches 4x2
        m_n = 1;
        m_in_frame = !e;
      end else if (m_in_frame) begin
        write = 1'b1;
        m_n++;
        if (e) begin
          if (m_n == NPIX) m_done = 1'b1;
          else m_geom = 1'b1;
          m_in_frame = 0;
        end else if (m_n == NPIX) begin
          m_geom = 1'b1;
          m_in_frame = 0;
        end
      end
    end
    if (write) begin
      if (f) m_ovf = 1'b1;
      else begin m_we = 1'b1; m_data = word_of(d); end
    end
  endtask

  // Apply one cycle of inputs and compare the registered outputs afterwards.
  task automatic step(input logic r, s, e, v, input logic [7:0] d, input logic f);
    rst = r; din_sop = s; din_eop = e; din_vld = v; din = d; fifo_full = f;
    model(r, s, e, v, d, f);
    @(posedge clk);
    #1;
    chk("wr_en", {31'b0, wr_en}, {31'b0, m_we});
    if (m_we) chk("wr_data", {16'b0, wr_data}, {16'b0, m_data});
    chk("frame_done", {31'b0, frame_done}, {31'b0, m_done});
    chk("err_geom", {31'b0, err_geom}, {31'b0, m_geom});
    chk("err_ovf", {31'b0, err_ovf}, {31'b0, m_ovf});
    if (wr_en) wr_cnt++;
    if (v && !r)
      $display("px rst=%0b sop=%0b eop=%0b din=%02h full=%0b -> wr_en=%0b wr_data=%04h done=%0b geom=%0b ovf=%0b",
               r, s, e, d, f, wr_en, wr_data, frame_done, err_geom, err_ovf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // One frame of npix pixels; eop_at/full_at of -1 means never.
  task automatic send_frame(input int npix, input int eop_at, input int full_at,
                            input bit gaps, input logic [7:0] base);
    for (int p = 0; p < npix; p++) begin
      if (gaps) idle(1);
      step(1'b0, p == 0, p == eop_at, 1'b1, base + 8'(p), p == full_at);
    end
  endtask

  typedef struct {
    logic        sop, eop, vld;
    logic [7:0]  d;
    logic        full;
    logic        x_we;
    logic [15:0] x_data;
    logic        x_done, x_geom, x_ovf;
  } vec_t;

  vec_t tbl [NPIX + 1];

  initial begin
    // Good frame 0x10..0x17 followed by an idle cycle.
    for (int i = 0; i < NPIX; i++) begin
      tbl[i].sop = (i == 0); tbl[i].eop = (i == NPIX - 1); tbl[i].vld = 1'b1;
      tbl[i].d = 8'h10 + 8'(i); tbl[i].full = 1'b0;
      tbl[i].x_we = 1'b1; tbl[i].x_data = word_of(8'h10 + 8'(i));
      tbl[i].x_done = (i == NPIX - 1); tbl[i].x_geom = 1'b0; tbl[i].x_ovf = 1'b0;
    end
    tbl[NPIX] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0};

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0);
    chk("reset_wr_data", {16'b0, wr_data}, 32'h0);

    // Table-driven good frame.
    wr_cnt = 0;
    foreach (tbl[i]) begin
      step(1'b0, tbl[i].sop, tbl[i].eop, tbl[i].vld, tbl[i].d, tbl[i].full);
      chk("tbl_wr_en", {31'b0, wr_en}, {31'b0, tbl[i].x_we});
      if (tbl[i].x_we) chk("tbl_wr_data", {16'b0, wr_data}, {16'b0, tbl[i].x_data});
      chk("tbl_done", {31'b0, frame_done}, {31'b0, tbl[i].x_done});
      chk("tbl_geom", {31'b0, err_geom}, {31'b0, tbl[i].x_geom});
      chk("tbl_ovf", {31'b0, err_ovf}, {31'b0, tbl[i].x_ovf});
    end
    chk("tbl_writes", wr_cnt, 8);

    // Same frame with a bubble before every pixel.
    wr_cnt = 0;
    send_frame(NPIX, NPIX - 1, -1, 1'b1, 8'h10);
    idle(2);
    chk("gapped_writes", wr_cnt, 8);

    // Early eop on pixel 6, then a correct frame clears err_geom.
    wr_cnt = 0;
    send_frame(6, 5, -1, 1'b0, 8'h20);
    idle(1);
    chk("early_eop_writes", wr_cnt, 6);
    chk("early_eop_geom", {31'b0, err_geom}, 32'd1);
    send_frame(NPIX, NPIX - 1, -1, 1'b0, 8'h30);
    idle(1);

    // Nine pixels without eop, then strays: only 8 writes.
    wr_cnt = 0;
    send_frame(9, -1, -1, 1'b0, 8'h40);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, i == 2, 1'b1, 8'hA0 + 8'(i), 1'b0);
    chk("overrun_writes", wr_cnt, 8);
    chk("overrun_geom", {31'b0, err_geom}, 32'd1);

    // FIFO full during pixel 3.
    wr_cnt = 0;
    send_frame(NPIX, NPIX - 1, 2, 1'b0, 8'h50);
    idle(1);
    chk("ovf_writes", wr_cnt, 7);
    chk("ovf_flag", {31'b0, err_ovf}, 32'd1);

    // sop and eop on the same pixel, then sop right after eop.
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h60, 1'b0);
    send_frame(NPIX, NPIX - 1, -1, 1'b0, 8'h61);
    send_frame(3, -1, -1, 1'b0, 8'h70);
    send_frame(NPIX, NPIX - 1, -1, 1'b0, 8'h78);  // early restart

`ifdef GRAY_SINK_RGB565_EN
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
    chk("rgb_ff", {16'b0, wr_data}, 32'h0000FFFF);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0);
    chk("rgb_80", {16'b0, wr_data}, 32'h00008410);
`endif

    // Reset mid-frame: outputs clear and strays are not written.
    send_frame(3, -1, 1, 1'b0, 8'h90);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h93, 1'b0);
    chk("rst_mid_state", {28'b0, wr_en, frame_done, err_geom, err_ovf}, 32'd0);
    wr_cnt = 0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, i == 3, 1'b1, 8'h94 + 8'(i), 1'b0);
    chk("rst_mid_writes", wr_cnt, 0);
    send_frame(NPIX, NPIX - 1, -1, 1'b0, 8'hC0);

    // Randomized frames with faults, gaps, overflow and occasional reset.
    for (int f = 0; f < 60; f++) begin
      int len;
      len = $urandom_range(5, 10);
      for (int p = 0; p < len; p++) begin
        logic s, e, v, fl, r;
        v  = ($urandom_range(0, 9) < 7);
        s  = (p == 0) || ($urandom_range(0, 39) == 0);
        e  = (p == len - 1) && ($urandom_range(0, 3) != 0);
        fl = ($urandom_range(0, 7) == 0);
        r  = ($urandom_range(0, 99) == 0);
        if (!v) step(1'b0, $urandom_range(0, 1), $urandom_range(0, 1), 1'b0, 8'($urandom), fl);
        step(r, s, e, 1'b1, 8'($urandom), fl);
      end
      idle($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_frame_sink.md
# gray_frame_sink

Terminating end of the 8-bit grayscale pixel stream (sop/eop/vld/data) produced by the image-processing chain. Checks frame geometry against the configured resolution and converts each accepted pixel into a 16-bit word for the SDRAM write FIFO. The stream has no backpressure, so FIFO overflow and geometry faults are flagged, never stalled. Sits between the last filter stage and the SDRAM write-port FIFO.

## Interface
- H_ACT, 640, active pixels per line, ≥2
- V_ACT, 480, active lines per frame, ≥1
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- din_sop  in  1  first pixel of frame, qualified by din_vld
- din_eop  in  1  last pixel of frame, qualified by din_vld
- din_vld  in  1  pixel valid
- din  in  8  gray pixel
- fifo_full  in  1  SDRAM write FIFO full
- wr_en  out  1  FIFO write strobe
- wr_data  out  16  FIFO write word
- frame_done  out  1  one-cycle pulse, frame closed with correct geometry
- err_geom  out  1  sticky geometry error
- err_ovf  out  1  sticky overflow, pixel dropped on fifo_full

## Operation
- Accepted pixel = din_vld high. sop/eop are ignored when din_vld is low.
- Counters: x in 0..H_ACT-1, y in 0..V_ACT-1. x wraps to 0 with y+1 after H_ACT-1.
- States:
  - IDLE: discard pixels without sop, no error. On vld&sop: write pixel, x=1, y=0, clear both sticky errors, go RUN.
  - RUN: on each accepted pixel, write it and advance the counters.
    - vld&sop: early restart. Set err_geom, treat the pixel as a fresh first pixel (x=1, y=0), stay RUN.
    - vld&eop with position == (H_ACT-1, V_ACT-1): pulse frame_done, go IDLE.
    - vld&eop at any other position: set err_geom, go IDLE.
    - vld at (H_ACT-1, V_ACT-1) without eop: write pixel, set err_geom, go DROP.
  - DROP: discard everything until vld&sop, then behave as IDLE's sop entry.
- sop and eop on the same pixel: sop handling applies first. With H_ACT*V_ACT>1 this is a geometry error; go IDLE.
- Write gating: a pixel to be written while fifo_full=1 is not written (wr_en stays 0) and sets err_ovf. Counting and state still advance.
- Sticky errors clear only on a sop entry or rst. If a set and a clear occur in the same cycle, set wins.
- Word format without the macro: wr_data = {8'h00, din}.

## Timing
- Reset values: wr_en=0, wr_data=0, frame_done=0, err_geom=0, err_ovf=0, state IDLE, x=y=0.
- Latency: wr_en/wr_data are registered 1 cycle after the accepting din_vld cycle. fifo_full is sampled in the accepting cycle.
- frame_done asserts in the same cycle as the wr_en of the eop pixel, or without wr_en if that pixel overflowed.
- err_geom and err_ovf assert 1 cycle after the offending pixel.
- Back-to-back pixels are supported with no bubbles. A sop immediately following an eop is accepted in the next cycle.
- rst mid-frame: all outputs 0 on the next edge and state IDLE. The remainder of the frame is discarded until a new sop.

## Configuration
- GRAY_SINK_RGB565_EN
  - Defined: wr_data = {din[7:3], din[7:2], din[7:3]} (gray replicated to RGB565).
  - Undefined: wr_data = {8'h00, din}.
- Timing, counting and flags are identical in both builds.

## Test plan
- H_ACT=4, V_ACT=2, 8 contiguous pixels 0x10..0x17, sop on first, eop on last → 8 wr_en, wr_data 0x0010..0x0017, frame_done one cycle with the last write, no errors.
- Same frame with din_vld toggled every other cycle → identical 8 writes, each 1 cycle after its vld, frame_done once.
- eop on 6th pixel → 6 writes, err_geom=1, no frame_done. Next correct frame → err_geom cleared at its sop, frame_done pulses.
- 9 pixels, no eop, then stray pixels → 8 writes, err_geom=1 after pixel 8, pixel 9 and strays dropped until next sop.
- fifo_full=1 during pixel 3 → 7 writes, pixel 3 missing, err_ovf=1, frame_done still pulses.
- Macro defined, din=0xFF → wr_data=0xFFFF. din=0x80 → wr_data=0x8410. rst asserted mid-frame → all outputs 0 next cycle, no writes until next sop.
